// File: rtl/lcv_mul_acc_arb.sv
// Round-robin arbiter and sequencer that shares one registered MAC among NUM_REQ requesters.
// Optional LCV_MUL_ACC_ARB_RND_EN drives mac_e with the Q15 rounding constant.
module lcv_mul_acc_arb #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*16-1:0]  req_a,
    input  logic [NUM_REQ*16-1:0]  req_b,
    input  logic [NUM_REQ*33-1:0]  req_c,
    output logic [15:0]            mac_a,
    output logic [15:0]            mac_b,
    output logic [32:0]            mac_c,
    output logic [32:0]            mac_d,
    output logic [32:0]            mac_e,
    input  logic [32:0]            mac_outp,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2:0]             rsp_id,
    output logic [32:0]            rsp_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [15:0] a_arr [8];
    logic [15:0] b_arr [8];
    logic [32:0] c_arr [8];

    logic [2:0]  ptr_reg;
    logic        win_found;
    logic [2:0]  win_idx;
    logic        credit;
    logic        grant_en;
    logic [OW-1:0] outstanding;

    logic [15:0] mac_a_reg;
    logic [15:0] mac_b_reg;
    logic [32:0] mac_c_reg;
    logic        s1_v_reg;
    logic [2:0]  s1_id_reg;
    logic        s2_v_reg;
    logic [2:0]  s2_id_reg;

    logic [35:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] fifo_count_reg;
    logic          push;
    logic          pop;
    logic [35:0]   head;

    // Slots beyond NUM_REQ are tied off so the operand mux can always be indexed with 3 bits.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_used
                assign a_arr[gi]     = req_a[16*gi +: 16];
                assign b_arr[gi]     = req_b[16*gi +: 16];
                assign c_arr[gi]     = req_c[33*gi +: 33];
                assign req_ready[gi] = grant_en && (win_idx == 3'(gi));
            end else begin : g_unused
                assign a_arr[gi] = '0;
                assign b_arr[gi] = '0;
                assign c_arr[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(ptr_reg) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = 3'((int'(ptr_reg) + k) % NUM_REQ);
            end
        end
    end

    // A pop in the same cycle deliberately does not free a credit.
    assign outstanding = OW'(fifo_count_reg) + OW'(s1_v_reg) + OW'(s2_v_reg);
    assign credit      = outstanding < OW'(FIFO_DEPTH);
    assign grant_en    = win_found && credit && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_a_reg <= '0;
            mac_b_reg <= '0;
            mac_c_reg <= '0;
            ptr_reg   <= '0;
            s1_v_reg  <= 1'b0;
            s1_id_reg <= '0;
            s2_v_reg  <= 1'b0;
            s2_id_reg <= '0;
        end else begin
            if (grant_en) begin
                mac_a_reg <= a_arr[win_idx];
                mac_b_reg <= b_arr[win_idx];
                mac_c_reg <= c_arr[win_idx];
                s1_id_reg <= win_idx;
                ptr_reg   <= (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
            end
            s1_v_reg  <= grant_en;
            s2_v_reg  <= s1_v_reg;
            s2_id_reg <= s1_id_reg;
        end
    end

    assign mac_a = mac_a_reg;
    assign mac_b = mac_b_reg;
    assign mac_c = mac_c_reg;
    assign mac_d = '0;
`ifdef LCV_MUL_ACC_ARB_RND_EN
    assign mac_e = 33'h0_0000_4000;
`else
    assign mac_e = '0;
`endif

    // s2 lines up with the MAC result of the operands registered two edges earlier.
    assign push = s2_v_reg;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {s2_id_reg, mac_outp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                fifo_count_reg <= fifo_count_reg + 1'b1;
            end else if (!push && pop) begin
                fifo_count_reg <= fifo_count_reg - 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr_reg];
    assign rsp_valid = (fifo_count_reg != '0);
    assign rsp_id    = rsp_valid ? head[35:33] : 3'd0;
    assign rsp_data  = rsp_valid ? head[32:0] : 33'd0;

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_count_reg == CW'(FIFO_DEPTH)));
`endif

endmodule

// File: tb/tb_lcv_mul_acc_arb.sv
// Directed self-checking bench for lcv_mul_acc_arb with a registered MAC model attached.
module tb_lcv_mul_acc_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [63:0]  req_a = '0;
    logic [63:0]  req_b = '0;
    logic [131:0] req_c = '0;
    logic [15:0]  mac_a, mac_b;
    logic [32:0]  mac_c, mac_d, mac_e;
    logic [32:0]  mac_outp = '0;
    logic [32:0]  mac_sum;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [2:0]   rsp_id;
    logic [32:0]  rsp_data;

    int checks   = 0;
    int failures = 0;

`ifdef LCV_MUL_ACC_ARB_RND_EN
    localparam logic [32:0] RND = 33'h0_0000_4000;
`else
    localparam logic [32:0] RND = 33'h0;
`endif

    lcv_mul_acc_arb #(.NUM_REQ(4), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_d     (mac_d),
        .mac_e     (mac_e),
        .mac_outp  (mac_outp),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    // Registered MAC: sign-extend operands to 33 bits, keep the low 33 bits of the sum.
    always_comb mac_sum = {{17{mac_a[15]}}, mac_a} * {{17{mac_b[15]}}, mac_b} + mac_c + mac_d + mac_e;
    always_ff @(posedge clk) mac_outp <= mac_sum;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [32:0] c);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_c[33*i +: 33] = c;
    endtask

    // Requester i gets a=i+1, b=2, c=10*i, so its result is 12*i+2 (+RND).
    task automatic set_std_ops;
        for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'd2, 33'(10 * i));
    endtask

    function automatic logic [32:0] std_exp(input int i);
        return 33'(12 * i + 2) + RND;
    endfunction

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got %b expected 0000", req_ready); end
        checks++;
        if (mac_a !== 16'h0 || mac_b !== 16'h0) begin failures++; $display("FAIL reset_mac_ab got %h/%h expected 0/0", mac_a, mac_b); end
        checks++;
        if (mac_c !== 33'h0 || mac_d !== 33'h0 || mac_e !== RND) begin
            failures++; $display("FAIL reset_mac_cde got %h/%h/%h expected 0/0/%h", mac_c, mac_d, mac_e, RND);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_data !== 33'h0) begin
            failures++; $display("FAIL reset_rsp got v=%b id=%0d d=%h expected 0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        tick;
    endtask

    task automatic test_single;
        do_reset;
        set_op(2, 16'd3, 16'hFFFC, 33'd100);
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got %b expected 0100", req_ready); end
        tick;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (mac_a !== 16'd3 || mac_b !== 16'hFFFC || mac_c !== 33'd100) begin
            failures++; $display("FAIL single_operands got %h/%h/%h expected 0003/fffc/064", mac_a, mac_b, mac_c);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_e0 got %b expected 0", rsp_valid); end
        tick;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_e1 got %b expected 0", rsp_valid); end
        tick;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_data !== 33'd88 + RND) begin
            failures++; $display("FAIL single_rsp got v=%b id=%0d d=%0d expected 1/2/%0d", rsp_valid, rsp_id, rsp_data, 33'd88 + RND);
        end
        tick;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_pop got %b expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin;
        do_reset;
        set_std_ops;
        rsp_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            req_valid = (t < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (t < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (t % 4))) begin
                    failures++; $display("FAIL rr_grant t=%0d got %b expected %b", t, req_ready, 4'(1 << (t % 4)));
                end
            end
            checks++;
            if (t >= 3 && t <= 10) begin
                if (rsp_valid !== 1'b1 || rsp_id !== 3'((t - 3) % 4) || rsp_data !== std_exp((t - 3) % 4)) begin
                    failures++; $display("FAIL rr_rsp t=%0d got v=%b id=%0d d=%0d expected 1/%0d/%0d",
                                         t, rsp_valid, rsp_id, rsp_data, (t - 3) % 4, std_exp((t - 3) % 4));
                end
            end else if (rsp_valid !== 1'b0) begin
                failures++; $display("FAIL rr_idle t=%0d got v=%b expected 0", t, rsp_valid);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] exp_g;
        int         exp_id;
        do_reset;
        set_std_ops;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int t = 0; t < 12; t++) begin
            if (t == 8) rsp_ready = 1'b1;
            @(negedge clk);
            if (t < 4)        exp_g = 4'(1 << t);
            else if (t == 9)  exp_g = 4'b0001;
            else if (t == 10) exp_g = 4'b0010;
            else if (t == 11) exp_g = 4'b0100;
            else              exp_g = 4'b0000;
            checks++;
            if (req_ready !== exp_g) begin
                failures++; $display("FAIL bp_grant t=%0d got %b expected %b", t, req_ready, exp_g);
            end
            if (t >= 3) begin
                exp_id = (t < 8) ? 0 : t - 8;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 3'(exp_id) || rsp_data !== std_exp(exp_id)) begin
                    failures++; $display("FAIL bp_rsp t=%0d got v=%b id=%0d d=%0d expected 1/%0d/%0d",
                                         t, rsp_valid, rsp_id, rsp_data, exp_id, std_exp(exp_id));
                end
            end
            tick;
        end
        req_valid = 4'h0;
    endtask

    task automatic test_wrap;
        logic found;
        do_reset;
        set_op(0, 16'h8000, 16'h8000, 33'h0_FFFF_FFFF);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        tick;
        req_valid = 4'b0000;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL wrap_timeout got no rsp_valid expected response within 10 cycles");
        end else if (rsp_data !== 33'h1_3FFF_FFFF + RND || rsp_id !== 3'd0) begin
            failures++; $display("FAIL wrap_data got id=%0d d=%h expected 0/%h", rsp_id, rsp_data, 33'h1_3FFF_FFFF + RND);
        end
        tick;
    endtask

    task automatic test_fairness;
        do_reset;
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL fair_first got %b expected 0010", req_ready); end
        tick;
        req_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL fair_ptr2 got %b expected 1000", req_ready); end
        tick;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL fair_then1 got %b expected 0010", req_ready); end
        tick;
        do_reset;
        req_valid = 4'b0010;
        tick;
        req_valid = 4'b0101;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL fair_ptr_is_2 got %b expected 0100", req_ready); end
        tick;
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid;
        do_reset;
        set_std_ops;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        tick;
        tick;
        tick;
        req_valid = 4'h0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_queued got %b expected 1", rsp_valid); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 3'd0 || rsp_data !== 33'h0 || mac_a !== 16'h0) begin
            failures++; $display("FAIL mid_cleared got v=%b id=%0d d=%h a=%h expected 0/0/0/0", rsp_valid, rsp_id, rsp_data, mac_a);
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_stale n=%0d got v=%b expected 0", n, rsp_valid); end
        end
        tick;
        req_valid = 4'hF;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr got %b expected 0001", req_ready); end
        tick;
        req_valid = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_wrap;
        test_fairness;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcv_mul_acc_arb.md
# lcv_mul_acc_arb

Round-robin arbiter and sequencer that shares one registered 16x16 multiply-accumulate unit (1-cycle registered output, `outp = a*b + c + d + e`) among up to 8 requesters. It grants at most one request per cycle and drives the MAC operand ports from registers. It tracks in-flight operations by id and returns tagged results in issue order through a credit-protected response FIFO. The block sits between requester pipelines and the MAC instance, so several users get full-throughput access without stalling the MAC, which has no clock enable.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `FIFO_DEPTH`, 4, response FIFO entries; power of two, minimum 4 (4 gives full throughput).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester grant; one-hot or zero.
- `req_a`  in  NUM_REQ*16  signed multiplicands; requester i uses slice [16i+15:16i].
- `req_b`  in  NUM_REQ*16  signed multipliers, sliced the same way.
- `req_c`  in  NUM_REQ*33  signed addends; requester i uses slice [33i+32:33i].
- `mac_a`, `mac_b`  out  16  registered MAC operands.
- `mac_c`, `mac_d`, `mac_e`  out  33  registered MAC addends.
- `mac_outp`  in  33  MAC result, valid one edge after operands are presented.
- `rsp_valid`  out  1  response available at FIFO head.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  3  index of the requester that owns `rsp_data`.
- `rsp_data`  out  33  signed result.

## Operation
- Credit check: `outstanding = s1_v + s2_v + fifo_count`. Grant only when `outstanding < FIFO_DEPTH`. A same-cycle FIFO pop does not return credit.
- Arbitration: round-robin over `req_valid`, with priority starting at pointer `ptr`.
  - `req_ready[i]` is high only for the winner, only while credit is available.
  - `req_ready` is combinational from `req_valid`, `ptr` and credit. Requesters must not make `req_valid` depend on `req_ready`.
- Acceptance: occurs at an edge where `req_valid[i] && req_ready[i]`.
  - Register `mac_a/b/c` from slice i.
  - Set `s1_v` and `s1_id = i`.
  - Set `ptr = (i+1) mod NUM_REQ`.
  - With no acceptance, `ptr` and the `mac_*` operands hold.
- Stage advance: each edge, `s2_v/s2_id <= s1_v/s1_id`. When `s2_v` is set, write `{s2_id, mac_outp}` into the FIFO.
- No overflow by construction. FIFO write while full is a design error; verification flags it with an assertion.
- Response path:
  - `rsp_valid = !fifo_empty`.
  - `rsp_id` and `rsp_data` come from the FIFO head and hold stable while `rsp_valid && !rsp_ready`.
  - Pop occurs when `rsp_valid && rsp_ready`.
- Simultaneous FIFO push and pop: both occur and `fifo_count` is unchanged; this is legal when full or empty.
- Arithmetic: the MAC computes a 33-bit two's-complement result that wraps modulo 2^33. `mac_d` is constantly 0; `mac_e` is set by configuration.
- Ordering: responses are returned in acceptance order, across all requesters.

## Timing
- Reset state: all of the following are 0 and the FIFO is empty:
  - `req_ready`, `mac_a`, `mac_b`, `mac_c`, `mac_d`.
  - `mac_e` (holds its configured constant when the configuration macro is defined).
  - `rsp_valid`, `rsp_id`, `rsp_data`.
  - `ptr`, `s1_v`, `s2_v`.
- Latency: with acceptance at edge E0, MAC output is valid after E1, the FIFO write happens at E2, and `rsp_valid` is high in the cycle after E2.
- Throughput: one acceptance per cycle while `rsp_ready` stays high (steady-state outstanding = 3).
- Backpressure: with `rsp_ready` low, exactly `FIFO_DEPTH` requests are accepted, then `req_ready` goes all-zero.
- Reset mid-operation: all in-flight and queued results are discarded. No response emerges after `rst` deasserts unless a new acceptance occurs.

## Configuration
- `LCV_MUL_ACC_ARB_RND_EN` defined: `mac_e` is driven to constant 33'sh0000_4000, for Q15 round-half-up before a downstream >>15. Every `rsp_data` includes the +16384.
- Macro not defined: `mac_e` is 0 and `rsp_data = a*b + c` (wrapped).

## Test plan
- Single request, NUM_REQ=4: requester 2 with a=3, b=-4, c=100, `rsp_ready`=1. Expect `rsp_id`=2 and `rsp_data`=88 in the cycle after E2 (16472 with the configuration macro defined).
- All 4 `req_valid` held high, `rsp_ready`=1. Expect grants 0,1,2,3,0,1… on consecutive cycles, responses in the same id order, and no idle cycles.
- `rsp_ready`=0 with all requesters valid. Expect exactly 4 acceptances, then `req_ready`=0. Raise `rsp_ready`: 4 responses drain in order, and new acceptances resume once `outstanding` drops below 4.
- Wrap case: a=-32768, b=-32768, c=33'h0_FFFF_FFFF (macro undefined). Expect `rsp_data`=-3221225473 (33'h1_3FFF_FFFF).
- Pointer fairness: requesters 1 and 3 valid with `ptr`=2. Expect 3 granted first, then 1; with only requester 1 valid, `ptr` advances to 2.
- Reset mid-operation: two requests in flight plus one queued, `rst` high for one cycle. Expect `rsp_valid`=0 from the next cycle, `ptr`=0, and no stale responses afterwards.
